// File: rtl/mem_access_unit.sv
// Data-memory access unit: aligns CPU loads/stores onto a 32-bit word bus, with a single outstanding request.
// Optional bus timeout is enabled by defining DMEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_dmtype,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_misalign,
    output logic        cpu_buserr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;

    state_t      state, state_next;
    logic [2:0]  dmtype_q;
    logic [1:0]  addr_lo_q;
    logic        req_bad;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        bus_timeout;

    always_comb begin
        req_bad    = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = cpu_wdata;
        case (cpu_dmtype)
            3'b000: req_bad = (cpu_addr[1:0] != 2'b00);
            3'b001, 3'b010: begin
                req_bad    = cpu_addr[0];
                be_calc    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{cpu_wdata[15:0]}};
            end
            3'b011, 3'b100: begin
                be_calc    = 4'b0001 << cpu_addr[1:0];
                wdata_calc = {4{cpu_wdata[7:0]}};
            end
            default: req_bad = 1'b1;
        endcase
        // Loads always fetch the whole word; lane selection happens on return.
        if (!cpu_we) begin
            be_calc = 4'b1111;
        end
    end

    always_comb begin
        byte_sel  = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        half_sel  = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = '0;
        case (dmtype_q)
            3'b000:  load_data = mem_rdata;
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = {16'h0000, half_sel};
            3'b011:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h000000, byte_sel};
            default: load_data = '0;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign bus_timeout = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt    <= '0;
            cpu_buserr <= 1'b0;
        end else begin
            if (state == BUS && !mem_ready) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if ((state == BUS && mem_ready) || (state == IDLE && cpu_req && req_bad)) begin
                cpu_buserr <= 1'b0;
            end else if (state == BUS && bus_timeout) begin
                cpu_buserr <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign bus_timeout        = 1'b0;
    assign cpu_buserr         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_next = req_bad ? ERR : BUS;
                end
            end
            BUS: begin
                if (mem_ready) begin
                    state_next = RESP;
                end else if (bus_timeout) begin
                    state_next = ERR;
                end
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state == BUS);
        cpu_done  = (state == RESP) || (state == ERR);
        cpu_stall = ((state == IDLE) && cpu_req) || (state == BUS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            dmtype_q     <= '0;
            addr_lo_q    <= '0;
            cpu_rdata    <= '0;
            cpu_misalign <= 1'b0;
        end else begin
            if (state == IDLE && cpu_req) begin
                mem_we    <= cpu_we;
                mem_addr  <= {cpu_addr[31:2], 2'b00};
                mem_be    <= be_calc;
                mem_wdata <= wdata_calc;
                dmtype_q  <= cpu_dmtype;
                addr_lo_q <= cpu_addr[1:0];
                if (req_bad) begin
                    cpu_rdata    <= '0;
                    cpu_misalign <= 1'b1;
                end
            end
            // Result registers are loaded only on the cycle that leads into a completion, so they hold in between.
            if (state == BUS && mem_ready) begin
                cpu_rdata    <= mem_we ? '0 : load_data;
                cpu_misalign <= 1'b0;
            end else if (state == BUS && bus_timeout) begin
                cpu_rdata    <= '0;
                cpu_misalign <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_dmtype;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_misalign;
    logic        cpu_buserr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  dmtype;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[15];

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_dmtype   (cpu_dmtype),
        .cpu_stall    (cpu_stall),
        .cpu_done     (cpu_done),
        .cpu_rdata    (cpu_rdata),
        .cpu_misalign (cpu_misalign),
        .cpu_buserr   (cpu_buserr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic string tag(input int i, input string s);
        return $sformatf("v%0d_%s", i, s);
    endfunction

    task automatic idle_inputs();
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_dmtype = '0;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_we     = v.we;
        cpu_addr   = v.addr;
        cpu_wdata  = v.wdata;
        cpu_dmtype = v.dmtype;
        #1;
        check(tag(idx, "stall_req"), 32'(cpu_stall), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        if (v.exp_mis) begin
            check(tag(idx, "err_done"), 32'(cpu_done), 32'd1);
            check(tag(idx, "err_misalign"), 32'(cpu_misalign), 32'd1);
            check(tag(idx, "err_rdata"), cpu_rdata, 32'h0);
            check(tag(idx, "err_memreq"), 32'(mem_req), 32'd0);
            check(tag(idx, "err_stall"), 32'(cpu_stall), 32'd0);
        end else begin
            for (int c = 1; c <= v.delay; c++) begin
                if (c > 1) begin
                    @(negedge clk);
                    #1;
                end
                check(tag(idx, "bus_req"), 32'(mem_req), 32'd1);
                check(tag(idx, "bus_stall"), 32'(cpu_stall), 32'd1);
                check(tag(idx, "bus_done"), 32'(cpu_done), 32'd0);
                check(tag(idx, "bus_we"), 32'(mem_we), 32'(v.we));
                check(tag(idx, "bus_addr"), mem_addr, v.addr & 32'hFFFF_FFFC);
                check(tag(idx, "bus_be"), 32'(mem_be), 32'(v.exp_be));
                check(tag(idx, "bus_wdata"), mem_wdata, v.exp_wdata);
                if (c == v.delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            #1;
            check(tag(idx, "resp_done"), 32'(cpu_done), 32'd1);
            check(tag(idx, "resp_rdata"), cpu_rdata, v.exp_rdata);
            check(tag(idx, "resp_misalign"), 32'(cpu_misalign), 32'd0);
            check(tag(idx, "resp_buserr"), 32'(cpu_buserr), 32'd0);
            check(tag(idx, "resp_stall"), 32'(cpu_stall), 32'd0);
            check(tag(idx, "resp_memreq"), 32'(mem_req), 32'd0);
        end
        @(negedge clk);
        #1;
        check(tag(idx, "after_done"), 32'(cpu_done), 32'd0);
        check(tag(idx, "after_rdata"), cpu_rdata, v.exp_rdata);
        check(tag(idx, "after_misalign"), 32'(cpu_misalign), 32'(v.exp_mis));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 3'b000, 1, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h13, 32'h0000_00A5, 3'b011, 1, 32'hFFFF_FFFF, 4'h8, 32'hA5A5_A5A5, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h12, 32'h0, 3'b001, 1, 32'h8001_0000, 4'hF, 32'h0, 32'hFFFF_8001, 1'b0};
        vecs[3]  = '{1'b0, 32'h12, 32'h0, 3'b010, 1, 32'h8001_0000, 4'hF, 32'h0, 32'h0000_8001, 1'b0};
        vecs[4]  = '{1'b0, 32'h01, 32'h0, 3'b011, 5, 32'h0000_8000, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b0};
        vecs[5]  = '{1'b0, 32'h01, 32'h0, 3'b100, 2, 32'h0000_8000, 4'hF, 32'h0, 32'h0000_0080, 1'b0};
        vecs[6]  = '{1'b0, 32'h06, 32'h0, 3'b000, 1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h00, 32'h0, 3'b111, 1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 32'h02, 32'h1234_ABCD, 3'b001, 3, 32'hFFFF_FFFF, 4'hC, 32'hABCD_ABCD, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h08, 32'h0, 3'b000, 2, 32'h89AB_CDEF, 4'hF, 32'h0, 32'h89AB_CDEF, 1'b0};
        vecs[10] = '{1'b0, 32'h11, 32'h0, 3'b001, 1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'h05, 32'h1, 3'b000, 1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 32'h00, 32'h1234_5678, 3'b011, 1, 32'hFFFF_FFFF, 4'h1, 32'h7878_7878, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h00, 32'h0, 3'b010, 1, 32'h1234_FFFF, 4'hF, 32'h0, 32'h0000_FFFF, 1'b0};
        vecs[14] = '{1'b0, 32'h02, 32'h0, 3'b011, 1, 32'h00FE_0000, 4'hF, 32'h0, 32'hFFFF_FFFE, 1'b0};

        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_memwe", 32'(mem_we), 32'd0);
        check("rst_membe", 32'(mem_be), 32'd0);
        check("rst_memaddr", mem_addr, 32'h0);
        check("rst_memwdata", mem_wdata, 32'h0);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_misalign", 32'(cpu_misalign), 32'd0);
        check("rst_buserr", 32'(cpu_buserr), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_txn(i, vecs[i]);
        end

        // mem_ready while idle must not complete anything or disturb held results
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("idle_ready_done", 32'(cpu_done), 32'd0);
            check("idle_ready_rdata", cpu_rdata, 32'hFFFF_FFFE);
        end
        mem_ready = 1'b0;

        // reset during the second BUS cycle
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h20;
        @(negedge clk);
        idle_inputs();
        #1;
        check("rstbus_req1", 32'(mem_req), 32'd1);
        @(negedge clk);
        check("rstbus_req2", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstbus_memreq", 32'(mem_req), 32'd0);
        check("rstbus_done", 32'(cpu_done), 32'd0);
        check("rstbus_stall", 32'(cpu_stall), 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("rstbus_nodone", 32'(cpu_done), 32'd0);
        end
        mem_ready = 1'b0;
        run_txn(100, vecs[2]);

        // memory that never answers
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 32'h40;
        cpu_wdata  = 32'h1111_2222;
        @(negedge clk);
        idle_inputs();
        #1;
`ifdef DMEM_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            check("tmo_memreq", 32'(mem_req), 32'd1);
            check("tmo_nodone", 32'(cpu_done), 32'd0);
        end
        @(negedge clk);
        #1;
        check("tmo_done", 32'(cpu_done), 32'd1);
        check("tmo_buserr", 32'(cpu_buserr), 32'd1);
        check("tmo_memreq_drop", 32'(mem_req), 32'd0);
        check("tmo_rdata", cpu_rdata, 32'h0);
        check("tmo_misalign", 32'(cpu_misalign), 32'd0);
        @(negedge clk);
        #1;
        check("tmo_after_done", 32'(cpu_done), 32'd0);
        check("tmo_after_buserr", 32'(cpu_buserr), 32'd1);
`else
        begin
            int hi;
            hi = 0;
            for (int c = 0; c < 20; c++) begin
                if (cpu_stall && mem_req && !cpu_done && !cpu_buserr) begin
                    hi++;
                end
                @(negedge clk);
                #1;
            end
            check("hang_stall_cycles", 32'(hi), 32'd20);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("hang_recover_stall", 32'(cpu_stall), 32'd0);
        check("hang_recover_memreq", 32'(mem_req), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
